// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the execute side and the
// data-memory responder.
interface dmem_responder_if #(parameter int N_BITS = 32);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [N_BITS-1:0] req_addr;
   logic [N_BITS-1:0] req_wdata;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic              rsp_valid;
   logic [N_BITS-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with byte-masked stores, aligned/extended sub-word
// loads, fault detection and a fixed-latency in-order response pipeline.
//
// state | meaning
// INIT  | clearing the RAM one word per cycle, requests refused
// RUN   | accepting one request per cycle
module dmem_responder #(
   parameter int N_BITS     = 32,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 1,
   parameter int INIT_CLEAR = 1
) (
   input logic             clk,
   input logic             rst_n,
   dmem_responder_if.slave bus
);
   // Lane logic assumes four byte lanes selected by addr[1:0] (N_BITS = 32).
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     cnt;
   logic              ready, ready_nxt, init_we;
   logic              accept, fault;
   logic [AW-1:0]     idx;
   logic [1:0]        off;
   logic [3:0]        be;
   logic [N_BITS-1:0] wd, rd_word, shifted, ld;
   logic [N_BITS-1:0] mem [DEPTH];

   logic [LATENCY-1:0] pv, pe;
   logic [N_BITS-1:0]  pd [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= (INIT_CLEAR != 0) ? INIT : RUN;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_nxt;
         ready <= ready_nxt;
         if (init_we) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      init_we   = 1'b0;
      case (state)
         INIT: begin
            init_we = 1'b1;
            if (cnt == AW'(DEPTH - 1)) state_nxt = RUN;
         end
         RUN: state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
      ready_nxt = (state_nxt == RUN);
   end

   assign bus.req_ready = ready;
   assign accept        = bus.req_valid & ready;
   assign idx           = bus.req_addr[AW+1:2];
   assign off           = bus.req_addr[1:0];

   always_comb begin
      fault = 1'b0;
      be    = 4'b0000;
      wd    = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            be = 4'b0001 << off;
            wd = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            fault = bus.req_addr[0];
            be    = 4'b0011 << off;
            wd    = {2{bus.req_wdata[15:0]}};
         end
         2'b10: begin
            fault = |bus.req_addr[1:0];
            be    = 4'b1111;
         end
         default: fault = 1'b1;
      endcase
      if (|bus.req_addr[N_BITS-1:AW+2]) fault = 1'b1;
   end

   // RAM is deliberately outside the reset domain; only INIT clears it.
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[cnt] <= '0;
      end else if (accept && bus.req_we && !fault) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
   end

   // Asynchronous read so any store committed on an earlier edge is visible.
   assign rd_word = mem[idx];
   assign shifted = rd_word >> {off, 3'b000};

   always_comb begin
      ld = shifted;
      case (bus.req_size)
         2'b00: ld = {{24{~bus.req_unsigned & shifted[7]}}, shifted[7:0]};
         2'b01: ld = {{16{~bus.req_unsigned & shifted[15]}}, shifted[15:0]};
         default: ld = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
         pe <= '0;
         for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
      end else begin
         pv[0] <= accept;
         pe[0] <= accept & fault;
         pd[0] <= (accept && !bus.req_we && !fault) ? ld : '0;
         for (int i = 1; i < LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end

   assign bus.rsp_valid = pv[LATENCY-1];
   assign bus.rsp_err   = pe[LATENCY-1];
   assign bus.rsp_data  = pd[LATENCY-1];
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (latency 1 and 3) share one stimulus stream
// and are checked against a byte-array reference model.
module tb_dmem_responder;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = 2'b00;

   dmem_responder_if #(.N_BITS(32)) bus_a();
   dmem_responder_if #(.N_BITS(32)) bus_b();

   assign bus_a.req_valid = req_valid;    assign bus_b.req_valid = req_valid;
   assign bus_a.req_we = req_we;          assign bus_b.req_we = req_we;
   assign bus_a.req_addr = req_addr;      assign bus_b.req_addr = req_addr;
   assign bus_a.req_wdata = req_wdata;    assign bus_b.req_wdata = req_wdata;
   assign bus_a.req_size = req_size;      assign bus_b.req_size = req_size;
   assign bus_a.req_unsigned = req_unsigned;
   assign bus_b.req_unsigned = req_unsigned;

   dmem_responder #(.N_BITS(32), .DEPTH(DEPTH), .LATENCY(1), .INIT_CLEAR(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   dmem_responder #(.N_BITS(32), .DEPTH(DEPTH), .LATENCY(3), .INIT_CLEAR(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t       qa[$], qb[$];
   int         total = 0, bad = 0;
   int         cyc = 0;
   logic [7:0] mb [DEPTH*4];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endfunction

   // Byte-addressed reference: fault rules, little-endian assembly, extension.
   function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns,
                                 output logic [31:0] data, output logic err);
      int n;
      logic [31:0] v;
      n    = 1 << size;
      err  = (size == 2'b11) || (addr >= 32'(DEPTH*4)) || ((addr % 32'(n)) != 0);
      data = '0;
      if (err) return;
      if (we) begin
         for (int k = 0; k < n; k++) mb[int'(addr) + k] = wdata[8*k +: 8];
      end else begin
         v = '0;
         for (int k = 0; k < n; k++) v[8*k +: 8] = mb[int'(addr) + k];
         if (!uns && n < 4 && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
         data = v;
      end
   endfunction

   function automatic void chk(input string nm, input logic v, input logic [31:0] d,
                               input logic e, input int nq, input exp_t f, output logic pop);
      pop = 1'b0;
      total++;
      if (nq > 0 && f.cyc <= cyc) begin
         pop = 1'b1;
         if (v !== 1'b1 || d !== f.data || e !== f.err || f.cyc != cyc) begin
            bad++;
            $display("FAIL %s rsp at cyc %0d: got v=%b data=%h err=%b, want data=%h err=%b at cyc %0d",
                     nm, cyc, v, d, e, f.data, f.err, f.cyc);
         end
      end else if (v !== 1'b0 || d !== 32'h0 || e !== 1'b0) begin
         bad++;
         $display("FAIL %s idle at cyc %0d: got v=%b data=%h err=%b, want all zero", nm, cyc, v, d, e);
      end
   endfunction

   always @(negedge clk) begin
      exp_t f;
      logic p;
      if (rst_n) begin
         f = '{0, 32'h0, 1'b0};
         if (qa.size() > 0) f = qa[0];
         chk("lat1", bus_a.rsp_valid, bus_a.rsp_data, bus_a.rsp_err, qa.size(), f, p);
         if (p) void'(qa.pop_front());
         f = '{0, 32'h0, 1'b0};
         if (qb.size() > 0) f = qb[0];
         chk("lat3", bus_b.rsp_valid, bus_b.rsp_data, bus_b.rsp_err, qb.size(), f, p);
         if (p) void'(qb.pop_front());
      end
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns);
      logic [31:0] d;
      logic        e;
      req_valid = 1'b1; req_we = we; req_addr = addr;
      req_wdata = wdata; req_size = size; req_unsigned = uns;
      model(we, addr, wdata, size, uns, d, e);
      qa.push_back('{cyc + 1, d, e});
      qb.push_back('{cyc + 3, d, e});
      @(negedge clk);
   endtask

   task automatic idle();
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_size = 2'($urandom);
      @(negedge clk);
   endtask

   // Releases reset with a bogus store pending and counts edges until ready.
   task automatic release_count(input int stop_at, output int n);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0;
      req_wdata = 32'hFFFF_FFFF; req_size = 2'b10;
      @(negedge clk);
      rst_n = 1'b1;
      cmp("ready_after_release_a", 32'(bus_a.req_ready), 32'h0);
      n = 0;
      while (n < 100) begin
         @(posedge clk); #1;
         n++;
         if (bus_a.req_ready) break;
         if (stop_at > 0 && n == stop_at) break;
      end
      req_valid = 1'b0;
   endtask

   task automatic run_init();
      int n;
      release_count(0, n);
      cmp("init_cycles", 32'(n), 32'(DEPTH));
      cmp("ready_b", 32'(bus_b.req_ready), 32'h1);
      for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
      @(negedge clk);
   endtask

   initial begin
      int n;
      logic [1:0]  sz;
      logic [31:0] a;
      for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
      repeat (2) @(negedge clk);
      cmp("reset_ready", 32'(bus_a.req_ready), 32'h0);
      cmp("reset_rsp", {bus_a.rsp_valid, bus_a.rsp_err, bus_b.rsp_valid, bus_b.rsp_err}, 32'h0);

      run_init();
      issue(1'b0, 32'h3C, 32'h0, 2'b10, 1'b0);

      issue(1'b1, 32'h8, 32'hDEAD_BEEF, 2'b10, 1'b0);
      for (int i = 8; i < 12; i++) issue(1'b0, 32'(i), 32'h0, 2'b00, 1'b0);
      issue(1'b0, 32'hA, 32'h0, 2'b01, 1'b1);

      issue(1'b1, 32'h9, 32'h1234_5655, 2'b00, 1'b0);
      issue(1'b0, 32'h8, 32'h0, 2'b10, 1'b0);

      issue(1'b1, 32'h4, 32'h1234_5678, 2'b10, 1'b0);
      issue(1'b0, 32'h5, 32'h0, 2'b01, 1'b0);
      issue(1'b1, 32'h6, 32'hFFFF_FFFF, 2'b10, 1'b0);
      issue(1'b1, 32'h0, 32'hFFFF_FFFF, 2'b11, 1'b0);
      issue(1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
      issue(1'b0, 32'h4, 32'h0, 2'b10, 1'b0);

      issue(1'b0, 32'h4, 32'h0, 2'b00, 1'b0);
      issue(1'b0, 32'h8, 32'h0, 2'b01, 1'b0);
      idle();
      issue(1'b0, 32'hB, 32'h0, 2'b00, 1'b1);
      repeat (4) idle();

      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end else begin
            sz = 2'($urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
            if ($urandom_range(0, 19) == 0) a = $urandom | 32'h40;
            issue(1'($urandom), a, $urandom, sz, 1'($urandom));
         end
      end
      repeat (5) idle();

      issue(1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
      issue(1'b0, 32'hC, 32'h0, 2'b10, 1'b0);
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      repeat (2) @(negedge clk);
      run_init();

      rst_n = 1'b0;
      @(negedge clk);
      release_count(7, n);
      cmp("mid_init_count", 32'(n), 32'd7);
      rst_n = 1'b0;
      #1;
      cmp("mid_init_ready", 32'(bus_a.req_ready), 32'h0);
      repeat (2) @(negedge clk);
      run_init();

      issue(1'b0, 32'h3C, 32'h0, 2'b10, 1'b0);
      issue(1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
      issue(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
      repeat (6) idle();

      cmp("queues_drained", 32'(qa.size() + qb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
